// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_HOLD_EN to add a one-word holding register so frames can be chained with no idle gap.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Tx_Valid,
    input  logic [DATA_BITS-1:0] i_Tx_Data,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Done
);

    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 ||
            PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2 || CNT_W < 1 ||
            ((CLKS_PER_BIT - 1) >> CNT_W) != 0) begin : g_bad_param
            $error("uart_tx_frame: illegal parameter value");
        end
    endgenerate

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       IDX_LAST  = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     bit_cnt, cnt_n;
    logic [3:0]           bit_idx, idx_n;
    logic                 stop_idx, stop_n;
    logic                 serial, serial_n;
    logic                 active, active_n;
    logic                 done, done_n;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_bit;
    logic [DATA_BITS-1:0] word;
    logic                 accept, bit_end, load, shift;

`ifdef UART_TX_HOLD_EN
    logic                 hold_full, hold_full_n, hold_wr, load_hold, frame_end;
    logic [DATA_BITS-1:0] hold_data;

    assign o_Tx_Ready = !hold_full && !i_Reset;
    assign word       = load_hold ? hold_data : i_Tx_Data;
    assign frame_end  = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
`else
    assign o_Tx_Ready = (state == IDLE) && !i_Reset;
    assign word       = i_Tx_Data;
`endif

    assign accept      = i_Tx_Valid && o_Tx_Ready;
    assign bit_end     = (bit_cnt == BIT_LAST);
    assign o_Tx_Serial = serial;
    assign o_Tx_Active = active;
    assign o_Tx_Done   = done;

    always_comb begin
        state_n  = state;
        cnt_n    = bit_cnt;
        idx_n    = bit_idx;
        stop_n   = stop_idx;
        serial_n = serial;
        active_n = active;
        done_n   = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
`ifdef UART_TX_HOLD_EN
        hold_full_n = hold_full;
        hold_wr     = 1'b0;
        load_hold   = 1'b0;
`endif
        if (state != IDLE) begin
            cnt_n = bit_end ? '0 : bit_cnt + 1'b1;
        end
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n  = START;
                    serial_n = 1'b0;
                    active_n = 1'b1;
                    cnt_n    = '0;
                    load     = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n  = DATA;
                    idx_n    = '0;
                    serial_n = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        if (PARITY_MODE != 0) begin
                            state_n  = PARITY;
                            serial_n = parity_bit;
                        end else begin
                            state_n  = STOP;
                            serial_n = 1'b1;
                            stop_n   = 1'b0;
                        end
                    end else begin
                        // shreg[0] is the bit on the line; the next one moves down as we shift
                        idx_n    = bit_idx + 1'b1;
                        serial_n = shreg[1];
                        shift    = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n  = STOP;
                    serial_n = 1'b1;
                    stop_n   = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx == STOP_LAST) begin
                        done_n = 1'b1;
`ifdef UART_TX_HOLD_EN
                        if (hold_full) begin
                            state_n     = START;
                            serial_n    = 1'b0;
                            load        = 1'b1;
                            load_hold   = 1'b1;
                            hold_full_n = 1'b0;
                        end else if (accept) begin
                            state_n  = START;
                            serial_n = 1'b0;
                            load     = 1'b1;
                        end else begin
                            state_n  = IDLE;
                            active_n = 1'b0;
                        end
`else
                        state_n  = IDLE;
                        active_n = 1'b0;
`endif
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef UART_TX_HOLD_EN
        // an accept that does not start a frame immediately parks the word in the hold register
        if (accept && state != IDLE && !frame_end) begin
            hold_wr     = 1'b1;
            hold_full_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            serial   <= 1'b1;
            active   <= 1'b0;
            done     <= 1'b0;
`ifdef UART_TX_HOLD_EN
            hold_full <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            bit_cnt  <= cnt_n;
            bit_idx  <= idx_n;
            stop_idx <= stop_n;
            serial   <= serial_n;
            active   <= active_n;
            done     <= done_n;
`ifdef UART_TX_HOLD_EN
            hold_full <= hold_full_n;
`endif
        end
    end

    always_ff @(posedge i_Clock) begin
        if (load) begin
            shreg      <= word;
            parity_bit <= (PARITY_MODE == 1) ? ~^word : ^word;
        end else if (shift) begin
            shreg <= shreg >> 1;
        end
`ifdef UART_TX_HOLD_EN
        if (hold_wr) begin
            hold_data <= i_Tx_Data;
        end
`endif
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four framing variants at CLKS_PER_BIT=4, scoreboard of expected line bits.
module tb_uart_tx_frame;
    localparam int CPB = 4;
`ifdef UART_TX_HOLD_EN
    localparam logic BUSY_RDY = 1'b1;
    localparam int   EXP_GAP  = 0;
    localparam int   NW       = 3;
`else
    localparam logic BUSY_RDY = 1'b0;
    localparam int   EXP_GAP  = 1;
    localparam int   NW       = 2;
`endif

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic       clk = 1'b0;
    logic [3:0] rst, vld;
    wire  [3:0] rdy, ser, act, dn;
    logic [8:0] dat [4];
    int db [4] = '{8, 7, 7, 9};
    int pm [4] = '{0, 2, 1, 0};
    int sb [4] = '{1, 2, 2, 1};
    frame_t exp_q [$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .CNT_W(4)) u_8n1 (
        .i_Clock(clk), .i_Reset(rst[0]), .i_Tx_Valid(vld[0]), .i_Tx_Data(dat[0][7:0]),
        .o_Tx_Ready(rdy[0]), .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(dn[0]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .CNT_W(4)) u_7e2 (
        .i_Clock(clk), .i_Reset(rst[1]), .i_Tx_Valid(vld[1]), .i_Tx_Data(dat[1][6:0]),
        .o_Tx_Ready(rdy[1]), .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(dn[1]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .CNT_W(4)) u_7o2 (
        .i_Clock(clk), .i_Reset(rst[2]), .i_Tx_Valid(vld[2]), .i_Tx_Data(dat[2][6:0]),
        .o_Tx_Ready(rdy[2]), .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(dn[2]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_MODE(0), .STOP_BITS(1), .CNT_W(4)) u_9n1 (
        .i_Clock(clk), .i_Reset(rst[3]), .i_Tx_Valid(vld[3]), .i_Tx_Data(dat[3]),
        .o_Tx_Ready(rdy[3]), .o_Tx_Serial(ser[3]), .o_Tx_Active(act[3]), .o_Tx_Done(dn[3]));

    // Line image of one frame: bit 0 is the start bit, followed by data LSB first, parity, stop bits.
    function automatic frame_t model(input int k, input logic [8:0] w);
        frame_t f;
        int     n;
        logic   p;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        p         = 1'b0;
        for (int i = 0; i < db[k]; i++) begin
            f.bits[1+i] = w[i];
            p ^= w[i];
        end
        n = 1 + db[k];
        if (pm[k] != 0) begin
            f.bits[n] = (pm[k] == 1) ? ~p : p;
            n++;
        end
        f.len = n + sb[k];
        return f;
    endfunction

    task automatic test_reset();
        rst = '1;
        vld = '0;
        for (int k = 0; k < 4; k++) dat[k] = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (ser[k] !== 1'b1 || act[k] !== 1'b0 || dn[k] !== 1'b0 || rdy[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: ser=%b act=%b done=%b rdy=%b, required 1 0 0 0",
                         k, ser[k], act[k], dn[k], rdy[k]);
            end
        end
        rst = '0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (rdy[k] !== 1'b1 || ser[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_after_reset[%0d]: rdy=%b ser=%b, required 1 1", k, rdy[k], ser[k]);
            end
        end
    endtask

    task automatic test_frame(input int k, input logic [8:0] w, input string name);
        frame_t f;
        int     to;
        @(negedge clk);
        vld[k] = 1'b1;
        dat[k] = w;
        to = 0;
        while (rdy[k] !== 1'b1 && to < 50) begin
            @(negedge clk);
            to++;
        end
        n_chk++;
        if (rdy[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_timeout: rdy=%b, required 1", name, rdy[k]);
        end
        exp_q.push_back(model(k, w));
        @(negedge clk);
        vld[k] = 1'b0;
        dat[k] = ~w;
        f = exp_q.pop_front();
        for (int c = 0; c < f.len * CPB; c++) begin
            n_chk++;
            if (ser[k] !== f.bits[c/CPB] || act[k] !== 1'b1 || dn[k] !== 1'b0 || rdy[k] !== BUSY_RDY) begin
                n_fail++;
                $display("FAIL %s_cycle%0d: ser=%b act=%b done=%b rdy=%b, required %b 1 0 %b",
                         name, c, ser[k], act[k], dn[k], rdy[k], f.bits[c/CPB], BUSY_RDY);
            end
            @(negedge clk);
        end
        n_chk++;
        if (dn[k] !== 1'b1 || act[k] !== 1'b0 || ser[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_end: done=%b act=%b ser=%b, required 1 0 1", name, dn[k], act[k], ser[k]);
        end
        @(negedge clk);
        n_chk++;
        if (dn[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_width: done=%b, required 0", name, dn[k]);
        end
    endtask

    task automatic test_reset_mid_frame();
        frame_t f;
        int     to;
        @(negedge clk);
        vld[0] = 1'b1;
        dat[0] = 9'h0A5;
        to = 0;
        while (rdy[0] !== 1'b1 && to < 50) begin
            @(negedge clk);
            to++;
        end
        exp_q.push_back(model(0, 9'h0A5));
        @(negedge clk);
        vld[0] = 1'b0;
        f = exp_q.pop_front();
        for (int c = 0; c <= 15; c++) begin
            n_chk++;
            if (ser[0] !== f.bits[c/CPB]) begin
                n_fail++;
                $display("FAIL abort_pre_cycle%0d: ser=%b, required %b", c, ser[0], f.bits[c/CPB]);
            end
            if (c < 15) @(negedge clk);
        end
        rst[0] = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ser[0] !== 1'b1 || act[0] !== 1'b0 || dn[0] !== 1'b0 || rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: ser=%b act=%b done=%b rdy=%b, required 1 0 0 0",
                     ser[0], act[0], dn[0], rdy[0]);
        end
        rst[0] = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            n_chk++;
            if (ser[0] !== 1'b1 || act[0] !== 1'b0 || dn[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_idle%0d: ser=%b act=%b done=%b, required 1 0 0", c, ser[0], act[0], dn[0]);
            end
        end
        test_frame(0, 9'h03C, "after_abort");
    endtask

    task automatic test_back_to_back();
        frame_t     f;
        logic [8:0] words [3];
        int         idx, c, gap, ndone, nfr, budget;
        logic       in_frame, was_in, acc_pend, end_prev, exp_rdy;
`ifdef UART_TX_HOLD_EN
        words = '{9'h011, 9'h022, 9'h033};
`else
        words = '{9'h001, 9'h002, 9'h000};
`endif
        idx = 0; c = 0; gap = 0; ndone = 0; nfr = 0;
        in_frame = 1'b0; end_prev = 1'b0;
        f = '{bits: '1, len: 1};
        @(negedge clk);
        vld[0] = 1'b1;
        dat[0] = words[0];
        for (budget = 0; budget < 400 && !(nfr == NW && ndone == NW && !in_frame); budget++) begin
            acc_pend = vld[0] && rdy[0];
            @(negedge clk);
            if (acc_pend) begin
                exp_q.push_back(model(0, words[idx]));
                idx++;
                if (idx < NW) dat[0] = words[idx];
                else begin
                    vld[0] = 1'b0;
                    dat[0] = 9'h0FF;
                end
            end
            was_in = in_frame;
            n_chk++;
            if (dn[0] !== end_prev) begin
                n_fail++;
                $display("FAIL b2b_done: done=%b, required %b", dn[0], end_prev);
            end
            if (dn[0] === 1'b1) ndone++;
            end_prev = 1'b0;
            if (!in_frame && ser[0] === 1'b0) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected_start: queue=%0d, required >0", exp_q.size());
                end else begin
                    f = exp_q.pop_front();
                    in_frame = 1'b1;
                    c = 0;
                    if (nfr > 0 && gap !== EXP_GAP) begin
                        n_fail++;
                        $display("FAIL b2b_gap: gap=%0d, required %0d", gap, EXP_GAP);
                    end
                end
            end else if (!in_frame && nfr > 0) begin
                gap++;
            end
            if (in_frame) begin
                n_chk++;
                if (ser[0] !== f.bits[c/CPB] || act[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_line f%0d c%0d: ser=%b act=%b, required %b 1", nfr, c, ser[0], act[0], f.bits[c/CPB]);
                end
                c++;
                if (c == f.len * CPB) begin
                    in_frame = 1'b0;
                    nfr++;
                    gap = 0;
                    end_prev = 1'b1;
                end
            end
`ifdef UART_TX_HOLD_EN
            exp_rdy = (exp_q.size() == 0);
`else
            exp_rdy = !was_in && (ser[0] === 1'b1);
`endif
            n_chk++;
            if (rdy[0] !== exp_rdy) begin
                n_fail++;
                $display("FAIL b2b_ready: rdy=%b, required %b", rdy[0], exp_rdy);
            end
        end
        vld[0] = 1'b0;
        n_chk++;
        if (nfr !== NW || ndone !== NW || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: frames=%0d done=%0d left=%0d, required %0d %0d 0",
                     nfr, ndone, exp_q.size(), NW, NW);
        end
    endtask

    initial begin
        test_reset();
        test_frame(0, 9'h0A5, "8n1_a5");
        test_frame(1, 9'h055, "7e2_55");
        test_frame(2, 9'h055, "7o2_55");
        test_frame(3, 9'h1FF, "9n1_1ff");
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
